// File: rtl/dct_2d_block_sequencer.sv
// 8x8 2-D DCT sequencer: time-shares one fixed-latency 8-point 1-D unit over a row pass
// and a column pass through a 64-word transpose buffer, then streams 8 coefficient rows.
module dct_2d_block_sequencer #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DCT_LATENCY = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [8*DATA_WIDTH-1:0] in_vec,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [8*DATA_WIDTH-1:0] dct_vec_out,
  input  logic [8*DATA_WIDTH-1:0] dct_vec_in,
  output logic [8*DATA_WIDTH-1:0] out_vec,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy
);

  localparam int unsigned VEC_W = 8 * DATA_WIDTH;
  localparam int          LAT   = int'(DCT_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE, S_ROW, S_ROW_WAIT, S_COL, S_COL_WAIT, S_OUT
  } state_t;

  // phase: 0 = row pass, 1 = column pass
  typedef struct packed {
    logic       valid;
    logic       phase;
    logic [2:0] idx;
  } tag_t;

  state_t                r_state;
  logic [3:0]            r_rows;
  logic [2:0]            r_col;
  logic [2:0]            r_out_idx;
  logic [VEC_W-1:0]      r_hold;
  tag_t                  r_pipe [LAT];
  logic [DATA_WIDTH-1:0] r_buf  [8][8];

  logic                  w_accept;
  tag_t                  w_issue;
  tag_t                  w_exit;
  logic [VEC_W-1:0]      w_col_vec;
  logic [VEC_W-1:0]      w_out_vec;

  assign in_ready  = !reset && ((r_state == S_IDLE) ||
                                ((r_state == S_ROW) && (r_rows < 4'd8)));
  assign out_valid = !reset && (r_state == S_OUT);
  assign out_last  = out_valid && (r_out_idx == 3'd7);
  assign busy      = !reset && (r_state != S_IDLE);
  assign w_accept  = in_valid && in_ready;
  assign w_exit    = r_pipe[LAT-1];
  assign out_vec   = w_out_vec;

  // Transposed read of the current column and straight read of the current output row
  always_comb begin
    w_col_vec = '0;
    w_out_vec = '0;
    for (int j = 0; j < 8; j++) begin
      w_col_vec[j*DATA_WIDTH +: DATA_WIDTH] = r_buf[3'(j)][r_col];
      w_out_vec[j*DATA_WIDTH +: DATA_WIDTH] = r_buf[r_out_idx][3'(j)];
    end
  end

  always_comb begin
    w_issue = '0;
    if (w_accept) begin
      w_issue = '{valid: 1'b1, phase: 1'b0, idx: r_rows[2:0]};
    end else if (r_state == S_COL) begin
      w_issue = '{valid: 1'b1, phase: 1'b1, idx: r_col};
    end
  end

  // Accepted rows pass straight through; otherwise the last issued vector is held
  always_comb begin
    dct_vec_out = r_hold;
    if (reset) begin
      dct_vec_out = '0;
    end else if (w_accept) begin
      dct_vec_out = in_vec;
    end else if (r_state == S_COL) begin
      dct_vec_out = w_col_vec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_rows    <= '0;
      r_col     <= '0;
      r_out_idx <= '0;
      r_hold    <= '0;
      for (int i = 0; i < LAT; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0] <= w_issue;
      for (int i = 1; i < LAT; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
      if (w_accept) begin
        r_hold <= in_vec;
      end else if (r_state == S_COL) begin
        r_hold <= w_col_vec;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rows  <= 4'd1;
            r_state <= S_ROW;
          end
        end
        S_ROW: begin
          if (w_accept) begin
            r_rows <= r_rows + 4'd1;
            if (r_rows == 4'd7) begin
              r_state <= S_ROW_WAIT;
            end
          end
        end
        S_ROW_WAIT: begin
          if (w_exit.valid && !w_exit.phase && (w_exit.idx == 3'd7)) begin
            r_col   <= '0;
            r_state <= S_COL;
          end
        end
        S_COL: begin
          r_col <= r_col + 3'd1;
          if (r_col == 3'd7) begin
            r_state <= S_COL_WAIT;
          end
        end
        S_COL_WAIT: begin
          if (w_exit.valid && w_exit.phase && (w_exit.idx == 3'd7)) begin
            r_out_idx <= '0;
            r_state   <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            if (r_out_idx == 3'd7) begin
              r_out_idx <= '0;
              r_rows    <= '0;
              r_state   <= S_IDLE;
            end else begin
              r_out_idx <= r_out_idx + 3'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Column results overwrite only their own column, which has already been read out
  always_ff @(posedge clk) begin
    if (!reset && w_exit.valid) begin
      for (int k = 0; k < 8; k++) begin
        if (!w_exit.phase) begin
          r_buf[w_exit.idx][3'(k)] <= dct_vec_in[k*DATA_WIDTH +: DATA_WIDTH];
        end else begin
          r_buf[3'(k)][w_exit.idx] <= dct_vec_in[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_dct_2d_block_sequencer.sv
// Directed bench for dct_2d_block_sequencer: three instances (latency 3, 1, 6), each with
// a behavioural 1-D unit (identity or 10*x+k), checked against hand-derived coefficient rows.
module tb_dct_2d_block_sequencer;

  localparam int unsigned DW = 32;
  localparam int unsigned VW = 8 * DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, in_valid, out_ready;
  logic [VW-1:0] in_vec;
  logic [VW-1:0] dvo3, dvi3, ov3, dvo1, dvi1, ov1, dvo6, dvi6, ov6;
  logic          ir3, ovl3, ol3, bz3, ir1, ovl1, ol1, bz1, ir6, ovl6, ol6, bz6;

  int mode;
  int cyc;
  int n_assert;
  int n_fail;

  logic [VW-1:0] d3 [3];
  logic [VW-1:0] d1 [1];
  logic [VW-1:0] d6 [6];

  dct_2d_block_sequencer #(.DATA_WIDTH(DW), .DCT_LATENCY(3)) u3 (
    .clk(clk), .reset(reset), .in_vec(in_vec), .in_valid(in_valid), .in_ready(ir3),
    .dct_vec_out(dvo3), .dct_vec_in(dvi3), .out_vec(ov3), .out_valid(ovl3),
    .out_ready(out_ready), .out_last(ol3), .busy(bz3));
  dct_2d_block_sequencer #(.DATA_WIDTH(DW), .DCT_LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .in_vec(in_vec), .in_valid(in_valid), .in_ready(ir1),
    .dct_vec_out(dvo1), .dct_vec_in(dvi1), .out_vec(ov1), .out_valid(ovl1),
    .out_ready(out_ready), .out_last(ol1), .busy(bz1));
  dct_2d_block_sequencer #(.DATA_WIDTH(DW), .DCT_LATENCY(6)) u6 (
    .clk(clk), .reset(reset), .in_vec(in_vec), .in_valid(in_valid), .in_ready(ir6),
    .dct_vec_out(dvo6), .dct_vec_in(dvi6), .out_vec(ov6), .out_valid(ovl6),
    .out_ready(out_ready), .out_last(ol6), .busy(bz6));

  function automatic logic [VW-1:0] f1d(input logic [VW-1:0] v, input int m);
    logic [VW-1:0] r;
    logic [DW-1:0] e;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      e = v[k*DW +: DW];
      r[k*DW +: DW] = (m == 1) ? 32'(10 * e + 32'(k)) : e;
    end
    return r;
  endfunction

  // Expected row k: mode 0 gives x[k][c]; mode 1 gives 100*x[k][c] + 10*c + k
  function automatic logic [VW-1:0] exp_row(input int base, input int m, input int k);
    logic [VW-1:0] r;
    int x;
    r = '0;
    for (int c = 0; c < 8; c++) begin
      x = base + k * 8 + c;
      r[c*DW +: DW] = (m == 1) ? 32'(100 * x + 10 * c + k) : 32'(x);
    end
    return r;
  endfunction

  assign dvi3 = d3[2];
  assign dvi1 = d1[0];
  assign dvi6 = d6[5];

  always @(posedge clk) begin
    d3[0] <= f1d(dvo3, mode);
    d3[1] <= d3[0];
    d3[2] <= d3[1];
    d1[0] <= f1d(dvo1, mode);
    d6[0] <= f1d(dvo6, mode);
    for (int i = 1; i < 6; i++) d6[i] <= d6[i-1];
  end

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_block(input int base, input bit gaps);
    for (int r = 0; r < 8; r++) begin
      in_vec   = exp_row(base, 0, r);
      in_valid = 1'b1;
      #1;
      for (int b = 0; b < 50 && !ir3; b++) tick();
      chk($sformatf("in_ready_row%0d", r), VW'(ir3), VW'(1));
      chk($sformatf("passthru_row%0d", r), dvo3, exp_row(base, 0, r));
      tick();
      if (gaps) begin
        in_valid = 1'b0;
        #1;
        chk($sformatf("hold_row%0d", r), dvo3, exp_row(base, 0, r));
        tick();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic recv_block(input int base, input int m, input int stall_row);
    int k = 0;
    int stalls = 0;
    int budget = 0;
    while (k < 8 && budget < 200) begin
      out_ready = !((k == stall_row) && (stalls < 5));
      #1;
      if (ovl3) begin
        chk($sformatf("out_vec_r%0d", k), ov3, exp_row(base, m, k));
        chk($sformatf("out_last_r%0d", k), VW'(ol3), VW'(k == 7));
        if (out_ready) k++;
        else stalls++;
      end
      tick();
      budget++;
    end
    out_ready = 1'b1;
    chk("recv_rows", VW'(k), VW'(8));
    chk("in_ready_after_last", VW'(ir3), VW'(1));
    chk("busy_after_last", VW'(bz3), VW'(0));
  endtask

  task automatic wait_idle();
    out_ready = 1'b1;
    for (int b = 0; b < 100 && (bz3 || bz1 || bz6); b++) tick();
    chk("all_idle", VW'(bz3 | bz1 | bz6), VW'(0));
  endtask

  initial begin
    int k3, k1, k6, f3, f1, f6;
    n_assert  = 0;
    n_fail    = 0;
    cyc       = 0;
    mode      = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_vec    = '0;
    tick();
    tick();
    chk("rst_in_ready", VW'(ir3), VW'(0));
    chk("rst_out_valid", VW'(ovl3), VW'(0));
    chk("rst_out_last", VW'(ol3), VW'(0));
    chk("rst_busy", VW'(bz3), VW'(0));
    chk("rst_dct_vec_out", dvo3, VW'(0));
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", VW'(ir3), VW'(1));
    chk("post_rst_busy", VW'(bz3), VW'(0));

    // Identity unit, ideal timing, all three latencies
    cyc = 0;
    for (int r = 0; r < 8; r++) begin
      in_vec   = exp_row(0, 0, r);
      in_valid = 1'b1;
      #1;
      chk($sformatf("c1_in_ready_%0d", r), VW'(ir3), VW'(1));
      chk($sformatf("c1_passthru_%0d", r), dvo3, in_vec);
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("c1_in_ready_cyc8", VW'(ir3), VW'(0));
    chk("c1_busy_cyc8", VW'(bz3), VW'(1));
    out_ready = 1'b1;
    k3 = 0; k1 = 0; k6 = 0; f3 = -1; f1 = -1; f6 = -1;
    for (int b = 0; b < 100 && (k3 < 8 || k1 < 8 || k6 < 8); b++) begin
      if (ovl3) begin
        if (f3 < 0) f3 = cyc;
        chk($sformatf("c1_L3_row%0d", k3), ov3, exp_row(0, 0, k3));
        k3++;
      end
      if (ovl1) begin
        if (f1 < 0) f1 = cyc;
        chk($sformatf("c1_L1_row%0d", k1), ov1, exp_row(0, 0, k1));
        k1++;
      end
      if (ovl6) begin
        if (f6 < 0) f6 = cyc;
        chk($sformatf("c1_L6_row%0d", k6), ov6, exp_row(0, 0, k6));
        k6++;
      end
      tick();
    end
    chk("c1_L3_rows", VW'(k3), VW'(8));
    chk("c1_L1_rows", VW'(k1), VW'(8));
    chk("c1_L6_rows", VW'(k6), VW'(8));
    chk("c1_L3_first_valid", VW'(f3), VW'(22));
    chk("c1_L1_first_valid", VW'(f1), VW'(18));
    chk("c1_L6_first_valid", VW'(f6), VW'(28));
    wait_idle();

    // 10*x+k unit exposes transpose orientation
    mode = 1;
    send_block(0, 1'b0);
    recv_block(0, 1, -1);
    wait_idle();

    // Input gaps 1,0,1,0
    mode = 0;
    send_block(0, 1'b1);
    recv_block(0, 0, -1);
    wait_idle();

    // Five-cycle output stall on row 3
    send_block(64, 1'b0);
    recv_block(64, 0, 3);
    wait_idle();

    // Reset during the column pass, then a fresh block
    send_block(0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    chk("c5_busy_in_col", VW'(bz3), VW'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("c5_busy_after_rst", VW'(bz3), VW'(0));
    chk("c5_out_valid_after_rst", VW'(ovl3), VW'(0));
    chk("c5_in_ready_after_rst", VW'(ir3), VW'(1));
    mode = 1;
    send_block(500, 1'b0);
    recv_block(500, 1, -1);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
